// File: rtl/matmul_job_arbiter.sv
// ---------------------------------------------------------------------------
// MatmulJobArbiter (module matmul_job_arbiter)
//
// Purpose:
//   Shares one matrix-multiply core between two requesters. A job is
//   IN_DEPTH in1 (tile) beats plus IN_DEPTH in2 (weight) beats. Jobs are
//   granted round-robin, and the beats are streamed through to the core.
//   The ID of every issued job is kept in a small tag FIFO so that results
//   coming back from the core are steered to the right requester in issue
//   order.
//
// Ports:
//   clk, rst                        clock (rising edge), synchronous active-low reset
//   rN_in1 / _valid / _ready        requester N tile beats        (N = 0, 1)
//   rN_in2 / _valid / _ready        requester N weight beats
//   rN_out / _valid / _ready        requester N result beats
//   core_in1 / _valid / _ready      tile beats towards the core
//   core_in2 / _valid / _ready      weight beats towards the core
//   core_out / _valid / _ready      result beats from the core
//   busy                            high while a job is being issued
//   owner                           requester of the current or last job
//
// Optional build macro:
//   MATMUL_ARB_PERF_EN  adds job_cnt0, job_cnt1 (jobs issued per requester)
//                       and stall_cnt (idle cycles blocked by a full tag
//                       FIFO); all three are 16-bit wrapping counters.
// ---------------------------------------------------------------------------
module matmul_job_arbiter #(
    parameter int IN1_BITS  = 32,
    parameter int IN2_BITS  = 24,
    parameter int OUT_BITS  = 96,
    parameter int IN_DEPTH  = 3,
    parameter int TAG_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,

    input  logic [IN1_BITS-1:0] r0_in1,
    input  logic                r0_in1_valid,
    output logic                r0_in1_ready,
    input  logic [IN2_BITS-1:0] r0_in2,
    input  logic                r0_in2_valid,
    output logic                r0_in2_ready,
    output logic [OUT_BITS-1:0] r0_out,
    output logic                r0_out_valid,
    input  logic                r0_out_ready,

    input  logic [IN1_BITS-1:0] r1_in1,
    input  logic                r1_in1_valid,
    output logic                r1_in1_ready,
    input  logic [IN2_BITS-1:0] r1_in2,
    input  logic                r1_in2_valid,
    output logic                r1_in2_ready,
    output logic [OUT_BITS-1:0] r1_out,
    output logic                r1_out_valid,
    input  logic                r1_out_ready,

    output logic [IN1_BITS-1:0] core_in1,
    output logic                core_in1_valid,
    input  logic                core_in1_ready,
    output logic [IN2_BITS-1:0] core_in2,
    output logic                core_in2_valid,
    input  logic                core_in2_ready,
    input  logic [OUT_BITS-1:0] core_out,
    input  logic                core_out_valid,
    output logic                core_out_ready,

    output logic                busy,
    output logic                owner
`ifdef MATMUL_ARB_PERF_EN
    ,
    output logic [15:0]         job_cnt0,
    output logic [15:0]         job_cnt1,
    output logic [15:0]         stall_cnt
`endif
);

    localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CW = $clog2(IN_DEPTH + 1);
    localparam logic [CW-1:0] BEATS = CW'(IN_DEPTH);
    localparam logic [PW:0]   TAGS  = (PW + 1)'(TAG_DEPTH);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic            owner_q, owner_d;
    logic            prio_q, prio_d;
    logic [CW-1:0]   in1Cnt_q, in1Cnt_d;
    logic [CW-1:0]   in2Cnt_q, in2Cnt_d;

    logic [TAG_DEPTH-1:0] tagMem_q;
    logic [PW-1:0]   wrPtr_q, rdPtr_q;
    logic [PW:0]     tagCount_q;

    logic            fifoFull, fifoEmpty, headId;
    logic            anyReq, grant, grantId;
    logic            issuing, in1Open, in2Open;
    logic            in1Ready, in2Ready, in1Fire, in2Fire;
    logic            selIn1Valid, selIn2Valid;
    logic            routeOk, push, pop;

    // Tag FIFO status and round-robin request evaluation. On a tie the
    // requester in prio_q wins; prio_q always points at the one not granted
    // last, and reset points it at r0.
    always_comb begin
        fifoFull  = (tagCount_q == TAGS);
        fifoEmpty = (tagCount_q == '0);
        headId    = tagMem_q[rdPtr_q];
        anyReq    = r0_in1_valid | r1_in1_valid;
        grantId   = (r0_in1_valid & r1_in1_valid) ? prio_q : r1_in1_valid;
        grant     = rst && (state_q == IDLE) && anyReq && !fifoFull;
        push      = grant;
    end

    // Issue-side datapath. The owner's channels are tied straight through to
    // the core; each channel closes on its own once IN_DEPTH beats have gone,
    // so in1 and in2 may finish at different times. Everything is gated with
    // rst so that valid/ready are quiet for the whole time reset is held.
    always_comb begin
        issuing     = rst && (state_q == ISSUE);
        in1Open     = issuing && (in1Cnt_q != BEATS);
        in2Open     = issuing && (in2Cnt_q != BEATS);

        core_in1    = owner_q ? r1_in1 : r0_in1;
        core_in2    = owner_q ? r1_in2 : r0_in2;
        selIn1Valid = owner_q ? r1_in1_valid : r0_in1_valid;
        selIn2Valid = owner_q ? r1_in2_valid : r0_in2_valid;

        core_in1_valid = in1Open && selIn1Valid;
        core_in2_valid = in2Open && selIn2Valid;
        in1Ready       = in1Open && core_in1_ready;
        in2Ready       = in2Open && core_in2_ready;

        r0_in1_ready = in1Ready && !owner_q;
        r1_in1_ready = in1Ready &&  owner_q;
        r0_in2_ready = in2Ready && !owner_q;
        r1_in2_ready = in2Ready &&  owner_q;

        in1Fire = core_in1_valid && core_in1_ready;
        in2Fire = core_in2_valid && core_in2_ready;

        busy  = issuing;
        owner = rst && owner_q;
    end

    // Result routing. The FIFO head names the requester whose result the
    // core will produce next; only that requester sees valid, and its ready
    // becomes the core's ready. Data is passed through untouched to both.
    always_comb begin
        routeOk        = rst && !fifoEmpty;
        r0_out         = core_out;
        r1_out         = core_out;
        r0_out_valid   = routeOk && !headId && core_out_valid;
        r1_out_valid   = routeOk &&  headId && core_out_valid;
        core_out_ready = routeOk && (headId ? r1_out_ready : r0_out_ready);
        pop            = core_out_valid && core_out_ready;
    end

    // FSM next-state. A grant in IDLE latches the owner, flips the tie
    // priority and zeroes both beat counters. ISSUE ends as soon as the
    // counters will both reach IN_DEPTH, so the last beat cycle is the last
    // ISSUE cycle and the following IDLE cycle is the single gap cycle in
    // which the next grant is decided.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        prio_d   = prio_q;
        in1Cnt_d = in1Cnt_q;
        in2Cnt_d = in2Cnt_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d  = ISSUE;
                    owner_d  = grantId;
                    prio_d   = !grantId;
                    in1Cnt_d = '0;
                    in2Cnt_d = '0;
                end
            end
            ISSUE: begin
                if (in1Fire) in1Cnt_d = in1Cnt_q + CW'(1);
                if (in2Fire) in2Cnt_d = in2Cnt_q + CW'(1);
                if ((in1Cnt_d == BEATS) && (in2Cnt_d == BEATS)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register. Reset drops any job in flight and forgets every
    // outstanding tag; results for beats the core already took are simply
    // no longer routed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            prio_q   <= 1'b0;
            in1Cnt_q <= '0;
            in2Cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            prio_q   <= prio_d;
            in1Cnt_q <= in1Cnt_d;
            in2Cnt_q <= in2Cnt_d;
        end
    end

    // Tag FIFO. TAG_DEPTH is a power of two, so the pointers wrap by plain
    // overflow. A push and a pop in the same cycle both happen and leave
    // the occupancy unchanged.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tagMem_q   <= '0;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            tagCount_q <= '0;
        end else begin
            if (push) begin
                tagMem_q[wrPtr_q] <= grantId;
                wrPtr_q           <= wrPtr_q + PW'(1);
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   tagCount_q <= tagCount_q + (PW + 1)'(1);
                2'b01:   tagCount_q <= tagCount_q - (PW + 1)'(1);
                default: tagCount_q <= tagCount_q;
            endcase
        end
    end

`ifdef MATMUL_ARB_PERF_EN
    logic [15:0] jobCnt0_q, jobCnt1_q, stallCnt_q;
    logic        jobDone, stallNow;

    // Performance events: a job counts when ISSUE hands back to IDLE, and a
    // stall is an IDLE cycle where someone wants to start but the tag FIFO
    // has no room.
    always_comb begin
        jobDone  = issuing && (state_d == IDLE);
        stallNow = rst && (state_q == IDLE) && anyReq && fifoFull;
    end

    // Wrapping 16-bit event counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            jobCnt0_q  <= '0;
            jobCnt1_q  <= '0;
            stallCnt_q <= '0;
        end else begin
            if (jobDone && !owner_q) jobCnt0_q  <= jobCnt0_q + 16'd1;
            if (jobDone &&  owner_q) jobCnt1_q  <= jobCnt1_q + 16'd1;
            if (stallNow)            stallCnt_q <= stallCnt_q + 16'd1;
        end
    end

    assign job_cnt0  = jobCnt0_q;
    assign job_cnt1  = jobCnt1_q;
    assign stall_cnt = stallCnt_q;
`endif

endmodule

// File: tb/tb_matmul_job_arbiter.sv
// ---------------------------------------------------------------------------
// TbMatmulJobArbiter (module tb_matmul_job_arbiter)
//
// Directed bench for matmul_job_arbiter with default parameters
// (IN_DEPTH = 3, TAG_DEPTH = 4). The core side is played directly from the
// stimulus sequence; every expected value below is worked out by hand.
// Inputs change 1 ns after a rising edge and outputs are sampled 1 ns after
// that, well clear of the next edge.
// ---------------------------------------------------------------------------
module tb_matmul_job_arbiter;

    logic        clk;
    logic        rst;

    logic [31:0] r0_in1, r1_in1, core_in1;
    logic [23:0] r0_in2, r1_in2, core_in2;
    logic [95:0] r0_out, r1_out, core_out;
    logic        r0_in1_valid, r0_in1_ready, r0_in2_valid, r0_in2_ready;
    logic        r1_in1_valid, r1_in1_ready, r1_in2_valid, r1_in2_ready;
    logic        r0_out_valid, r0_out_ready, r1_out_valid, r1_out_ready;
    logic        core_in1_valid, core_in1_ready, core_in2_valid, core_in2_ready;
    logic        core_out_valid, core_out_ready;
    logic        busy, owner;
`ifdef MATMUL_ARB_PERF_EN
    logic [15:0] job_cnt0, job_cnt1, stall_cnt;
`endif

    int checkCount = 0;
    int errorCount = 0;

    matmul_job_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .r0_in1         (r0_in1),
        .r0_in1_valid   (r0_in1_valid),
        .r0_in1_ready   (r0_in1_ready),
        .r0_in2         (r0_in2),
        .r0_in2_valid   (r0_in2_valid),
        .r0_in2_ready   (r0_in2_ready),
        .r0_out         (r0_out),
        .r0_out_valid   (r0_out_valid),
        .r0_out_ready   (r0_out_ready),
        .r1_in1         (r1_in1),
        .r1_in1_valid   (r1_in1_valid),
        .r1_in1_ready   (r1_in1_ready),
        .r1_in2         (r1_in2),
        .r1_in2_valid   (r1_in2_valid),
        .r1_in2_ready   (r1_in2_ready),
        .r1_out         (r1_out),
        .r1_out_valid   (r1_out_valid),
        .r1_out_ready   (r1_out_ready),
        .core_in1       (core_in1),
        .core_in1_valid (core_in1_valid),
        .core_in1_ready (core_in1_ready),
        .core_in2       (core_in2),
        .core_in2_valid (core_in2_valid),
        .core_in2_ready (core_in2_ready),
        .core_out       (core_out),
        .core_out_valid (core_out_valid),
        .core_out_ready (core_out_ready),
        .busy           (busy),
        .owner          (owner)
`ifdef MATMUL_ARB_PERF_EN
        ,
        .job_cnt0       (job_cnt0),
        .job_cnt1       (job_cnt1),
        .stall_cnt      (stall_cnt)
`endif
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and land 1 ns past the last one.
    task automatic applyStimulus(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One comparison: counts it, and on a miss reports tag, observed, expected.
    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        // ------------------------------------------------ reset state
        rst = 1'b0;
        r0_in1 = '0; r0_in2 = '0; r1_in1 = 32'h1111_0000; r1_in2 = 24'h22_0000;
        r0_in1_valid = 0; r0_in2_valid = 0; r1_in1_valid = 0; r1_in2_valid = 0;
        r0_out_ready = 1; r1_out_ready = 1;
        core_in1_ready = 1; core_in2_ready = 1;
        core_out = '0; core_out_valid = 0;
        applyStimulus(2);
        core_out_valid = 1; #1;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_owner", owner, 0);
        checkOutput("rst_core_out_ready", core_out_ready, 0);
        checkOutput("rst_r0_out_valid", r0_out_valid, 0);
        checkOutput("rst_r1_out_valid", r1_out_valid, 0);
        checkOutput("rst_core_in1_valid", core_in1_valid, 0);
        core_out_valid = 0;
        rst = 1'b1;
        applyStimulus(1);

        // ------------------------------------------------ r0 alone, 3+3 beats
        $display("[TB] single job from r0");
        r0_in1_valid = 1; r0_in2_valid = 1;
        r0_in1 = 32'hA000_0000; r0_in2 = 24'hB0_0000; #1;
        checkOutput("t1_idle_r0_in1_ready", r0_in1_ready, 0);
        checkOutput("t1_idle_busy", busy, 0);
        applyStimulus(1);
        checkOutput("t1_owner", owner, 0);
        for (int b = 0; b < 3; b++) begin
            r0_in1 = 32'hA000_0000 + b; r0_in2 = 24'hB0_0000 + b; #1;
            checkOutput($sformatf("t1_busy_b%0d", b), busy, 1);
            checkOutput($sformatf("t1_core_in1_b%0d", b), core_in1, 32'hA000_0000 + b);
            checkOutput($sformatf("t1_core_in2_b%0d", b), core_in2, 24'hB0_0000 + b);
            checkOutput($sformatf("t1_core_in1_valid_b%0d", b), core_in1_valid, 1);
            checkOutput($sformatf("t1_r0_in1_ready_b%0d", b), r0_in1_ready, 1);
            checkOutput($sformatf("t1_r0_in2_ready_b%0d", b), r0_in2_ready, 1);
            checkOutput($sformatf("t1_r1_in1_ready_b%0d", b), r1_in1_ready, 0);
            checkOutput($sformatf("t1_r1_in2_ready_b%0d", b), r1_in2_ready, 0);
            applyStimulus(1);
        end
        r0_in1_valid = 0; r0_in2_valid = 0; #1;
        checkOutput("t1_done_busy", busy, 0);
        checkOutput("t1_done_core_in1_valid", core_in1_valid, 0);
        core_out = 96'h0C0C_0000_0000_0000_0000_0001; core_out_valid = 1; #1;
        checkOutput("t1_r0_out_valid", r0_out_valid, 1);
        checkOutput("t1_r0_out", r0_out, 96'h0C0C_0000_0000_0000_0000_0001);
        checkOutput("t1_r1_out_valid", r1_out_valid, 0);
        checkOutput("t1_core_out_ready", core_out_ready, 1);
        applyStimulus(1);
        checkOutput("t1_empty_core_out_ready", core_out_ready, 0);
        checkOutput("t1_empty_r0_out_valid", r0_out_valid, 0);
        core_out_valid = 0;

        // ------------------------------------------------ round robin + FIFO full
        $display("[TB] both requesters, round robin until the tag FIFO fills");
        rst = 1'b0;
        applyStimulus(1);
        rst = 1'b1;
        r0_in1_valid = 1; r0_in2_valid = 1; r1_in1_valid = 1; r1_in2_valid = 1;
        applyStimulus(1);
        for (int j = 0; j < 4; j++) begin
            checkOutput($sformatf("t2_owner_j%0d", j), owner, (j % 2 == 1) ? 1 : 0);
            checkOutput($sformatf("t2_busy_j%0d", j), busy, 1);
            checkOutput($sformatf("t2_r0_in1_ready_j%0d", j), r0_in1_ready, (j % 2 == 0) ? 1 : 0);
            checkOutput($sformatf("t2_r1_in1_ready_j%0d", j), r1_in1_ready, (j % 2 == 1) ? 1 : 0);
            applyStimulus(3);
            checkOutput($sformatf("t2_gap_busy_j%0d", j), busy, 0);
            applyStimulus(1);
        end
        checkOutput("t2_full_busy0", busy, 0);
        applyStimulus(2);
        checkOutput("t2_full_busy1", busy, 0);
        checkOutput("t2_full_core_in1_valid", core_in1_valid, 0);
`ifdef MATMUL_ARB_PERF_EN
        checkOutput("t2_stall_cnt", stall_cnt, 3);
        checkOutput("t2_job_cnt0", job_cnt0, 2);
        checkOutput("t2_job_cnt1", job_cnt1, 2);
`endif
        core_out = 96'h0C0C_0000_0000_0000_0000_0002; core_out_valid = 1; #1;
        checkOutput("t2_pop_r0_out_valid", r0_out_valid, 1);
        checkOutput("t2_pop_r1_out_valid", r1_out_valid, 0);
        checkOutput("t2_pop_core_out_ready", core_out_ready, 1);
        applyStimulus(1);
        core_out_valid = 0; #1;
        checkOutput("t2_after_pop_busy", busy, 0);
        applyStimulus(1);
        checkOutput("t2_fifth_busy", busy, 1);
        checkOutput("t2_fifth_owner", owner, 0);
`ifdef MATMUL_ARB_PERF_EN
        checkOutput("t2_stall_cnt_final", stall_cnt, 4);
`endif
        applyStimulus(3);
        r0_in1_valid = 0; r0_in2_valid = 0; r1_in1_valid = 0; r1_in2_valid = 0; #1;
        checkOutput("t2_fifth_done_busy", busy, 0);

        // ------------------------------------------------ in-order results, r1 stalls
        // Tag FIFO now holds r1, r0, r1, r0.
        $display("[TB] results r1 then r0 with r1 back-pressuring");
        r1_out_ready = 0;
        core_out = 96'h0C0C_0000_0000_0000_0000_0003; core_out_valid = 1; #1;
        checkOutput("t3_r1_out_valid", r1_out_valid, 1);
        checkOutput("t3_r0_out_valid", r0_out_valid, 0);
        checkOutput("t3_r1_out", r1_out, 96'h0C0C_0000_0000_0000_0000_0003);
        checkOutput("t3_hold_core_out_ready", core_out_ready, 0);
        applyStimulus(1);
        checkOutput("t3_hold2_core_out_ready", core_out_ready, 0);
        checkOutput("t3_hold2_r0_out_valid", r0_out_valid, 0);
        r1_out_ready = 1; #1;
        checkOutput("t3_release_core_out_ready", core_out_ready, 1);
        applyStimulus(1);
        core_out = 96'h0C0C_0000_0000_0000_0000_0004; #1;
        checkOutput("t3_next_r0_out_valid", r0_out_valid, 1);
        checkOutput("t3_next_r1_out_valid", r1_out_valid, 0);
        checkOutput("t3_next_r0_out", r0_out, 96'h0C0C_0000_0000_0000_0000_0004);
        applyStimulus(1);
        checkOutput("t3_third_r1_out_valid", r1_out_valid, 1);
        applyStimulus(1);
        checkOutput("t3_fourth_r0_out_valid", r0_out_valid, 1);
        applyStimulus(1);
        checkOutput("t3_empty_core_out_ready", core_out_ready, 0);
        checkOutput("t3_empty_r0_out_valid", r0_out_valid, 0);
        checkOutput("t3_empty_r1_out_valid", r1_out_valid, 0);
        core_out_valid = 0;

        // ------------------------------------------------ in2 lags in1
        $display("[TB] in2 arriving five cycles after in1");
        r0_in1_valid = 1; r0_in2_valid = 0;
        applyStimulus(1);
        checkOutput("t4_owner", owner, 0);
        checkOutput("t4_core_in1_valid", core_in1_valid, 1);
        checkOutput("t4_core_in2_valid", core_in2_valid, 0);
        applyStimulus(3);
        r0_in1_valid = 0; #1;
        checkOutput("t4_in1_done_busy", busy, 1);
        checkOutput("t4_in1_done_core_in1_valid", core_in1_valid, 0);
        checkOutput("t4_in1_done_r0_in1_ready", r0_in1_ready, 0);
        checkOutput("t4_in1_done_r0_in2_ready", r0_in2_ready, 1);
        applyStimulus(2);
        r0_in2_valid = 1; #1;
        checkOutput("t4_in2_core_in2_valid", core_in2_valid, 1);
        checkOutput("t4_in2_core_in1_valid", core_in1_valid, 0);
        applyStimulus(2);
        checkOutput("t4_in2_last_busy", busy, 1);
        applyStimulus(1);
        r0_in2_valid = 0; #1;
        checkOutput("t4_done_busy", busy, 0);

        // ------------------------------------------------ reset mid-job
        $display("[TB] reset after two of three beats");
        r0_in1_valid = 1; r0_in2_valid = 1;
        applyStimulus(1);
        checkOutput("t5_busy", busy, 1);
        applyStimulus(2);
        rst = 1'b0; r0_in1_valid = 0; r0_in2_valid = 0; #1;
        checkOutput("t5_inrst_busy", busy, 0);
        checkOutput("t5_inrst_core_in1_valid", core_in1_valid, 0);
        checkOutput("t5_inrst_r0_in1_ready", r0_in1_ready, 0);
        applyStimulus(1);
        rst = 1'b1; core_out_valid = 1; #1;
        checkOutput("t5_after_busy", busy, 0);
        checkOutput("t5_after_owner", owner, 0);
        checkOutput("t5_after_core_out_ready", core_out_ready, 0);
        checkOutput("t5_after_r0_out_valid", r0_out_valid, 0);
        checkOutput("t5_after_core_in1_valid", core_in1_valid, 0);
        core_out_valid = 0;
        r1_in1 = 32'h1111_00AA; r1_in1_valid = 1; r1_in2_valid = 1; #1;
        checkOutput("t5_idle_r1_in1_ready", r1_in1_ready, 0);
        applyStimulus(1);
        checkOutput("t5_r1_owner", owner, 1);
        checkOutput("t5_r1_busy", busy, 1);
        checkOutput("t5_r1_in1_ready", r1_in1_ready, 1);
        checkOutput("t5_r0_in1_ready", r0_in1_ready, 0);
        checkOutput("t5_core_in1", core_in1, 32'h1111_00AA);
        applyStimulus(2);
        checkOutput("t5_r1_third_busy", busy, 1);
        applyStimulus(1);
        r1_in1_valid = 0; r1_in2_valid = 0; #1;
        checkOutput("t5_r1_done_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/matmul_job_arbiter.md
MATMUL_JOB_ARBITER -- requirements
Module: matmul_job_arbiter

Interface
REQ-001 The block SHALL have parameter IN1_BITS, default 32: flattened bit width of one data_in1 beat (one tile).
REQ-002 The block SHALL have parameter IN2_BITS, default 24: flattened bit width of one data_in2 (weight) beat.
REQ-003 The block SHALL have parameter OUT_BITS, default 96: flattened bit width of one result beat.
REQ-004 The block SHALL have parameter IN_DEPTH, default 3: number of in1 beats and in2 beats per job.
REQ-005 The block SHALL have parameter TAG_DEPTH, default 4: maximum number of jobs issued but without a returned result; power of two, at least 2.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-008 For each requester N in {0,1}, the block SHALL have port rN_in1, input, IN1_BITS: data_in1 beat, with rN_in1_valid (input, 1) and rN_in1_ready (output, 1).
REQ-009 For each requester N, the block SHALL have port rN_in2, input, IN2_BITS: weight beat, with rN_in2_valid (input, 1) and rN_in2_ready (output, 1).
REQ-010 For each requester N, the block SHALL have port rN_out, output, OUT_BITS: result beat, with rN_out_valid (output, 1) and rN_out_ready (input, 1).
REQ-011 On the core side, the block SHALL have core_in1 (output, IN1_BITS) with core_in1_valid (output, 1) and core_in1_ready (input, 1).
REQ-012 On the core side, the block SHALL have core_in2 (output, IN2_BITS) with core_in2_valid (output, 1) and core_in2_ready (input, 1).
REQ-013 On the core side, the block SHALL have core_out (input, OUT_BITS) with core_out_valid (input, 1) and core_out_ready (output, 1).
REQ-014 The block SHALL have status outputs busy (output, 1: FSM in ISSUE) and owner (output, 1: requester granted the current or last job).

Function
REQ-015 The FSM SHALL have two states: IDLE and ISSUE.
REQ-016 In IDLE, requester N is requesting when rN_in1_valid=1; a grant SHALL occur only if the tag FIFO holds fewer than TAG_DEPTH entries.
REQ-017 Arbitration SHALL be round-robin: if both requesters request, grant the one not granted last; if one requests, grant it; the first grant after reset with both requesting goes to r0.
REQ-018 On a grant, the block SHALL push the owner ID into the tag FIFO, set owner, clear both beat counters and enter ISSUE on the next cycle.
REQ-019 In ISSUE, core_in1, core_in1_valid and rOWNER_in1_ready SHALL be combinationally connected to rOWNER_in1, rOWNER_in1_valid and core_in1_ready; the in2 channel SHALL be connected the same way.
REQ-020 The in1 and in2 channels SHALL be counted independently; a channel whose count has reached IN_DEPTH SHALL drive valid and ready low.
REQ-021 When both counts equal IN_DEPTH, the FSM SHALL return to IDLE; this gives a mandatory one-cycle gap between jobs.
REQ-022 In IDLE, and for the non-owner at all times, all requester in1/in2 ready outputs and core_in1_valid/core_in2_valid SHALL be 0.
REQ-023 When the tag FIFO is non-empty, core_out SHALL be routed to the requester at the FIFO head.
REQ-024 That head requester SHALL see rHEAD_out_valid = core_out_valid, and core_out_ready SHALL equal rHEAD_out_ready.
REQ-025 The other requester's out_valid SHALL be 0.
REQ-026 When the tag FIFO is empty, core_out_ready SHALL be 0.
REQ-027 The tag FIFO SHALL pop on each core_out handshake; a push and a pop in the same cycle SHALL both take effect.
REQ-028 The FIFO pointers SHALL wrap modulo TAG_DEPTH.
REQ-029 Results SHALL return in issue order; rN_out data SHALL be core_out unmodified, with zero added latency.

Reset
REQ-030 With rst=0 at a clock edge, the block SHALL enter IDLE, empty the tag FIFO, clear the beat counters and set the round-robin pointer so that r0 wins a tie.
REQ-031 During and after reset, owner, busy and all valid/ready outputs SHALL be 0.
REQ-032 A reset asserted mid-job SHALL abort the job and discard all outstanding tags; beats already accepted by the core are not tracked.

Configuration
REQ-033 With MATMUL_ARB_PERF_EN defined, the block SHALL add outputs job_cnt0 and job_cnt1 (16 bits each, wrapping), incremented when a job of that requester completes issue (ISSUE to IDLE).
REQ-034 With MATMUL_ARB_PERF_EN defined, the block SHALL add output stall_cnt (16 bits, wrapping), incremented in every IDLE cycle in which some rN_in1_valid=1 but the FIFO is full.
REQ-035 With MATMUL_ARB_PERF_EN defined, all three counters SHALL reset to 0.
REQ-036 With MATMUL_ARB_PERF_EN undefined, those ports and counters SHALL NOT exist, and the behaviour SHALL otherwise be identical.

Verification
REQ-037 The bench SHALL cover: r0 only, IN_DEPTH=3, core always ready -> 3 in1 and 3 in2 beats pass; busy is high for 3 cycles; r0_out receives the result; r1 readies stay 0.
REQ-038 The bench SHALL cover: r0 and r1 both valid from reset -> grant order r0, r1, r0, r1; owner toggles; one idle cycle between jobs.
REQ-039 The bench SHALL cover: TAG_DEPTH=4, core_out_valid held 0 -> 4 jobs issue, the 5th is blocked; stall_cnt increments each blocked cycle; one result popped -> the 5th is granted.
REQ-040 The bench SHALL cover: in2 lags in1 by 5 cycles -> in1 completes and its valid/ready drop; the FSM stays in ISSUE until the 3rd in2 beat.
REQ-041 The bench SHALL cover: results for the sequence r1, r0 with r1_out_ready=0 -> r0 result is held at the core (core_out_ready=0) until r1 accepts; order is preserved.
REQ-042 The bench SHALL cover: rst=0 after 2 of 3 beats -> next cycle IDLE, FIFO empty, all outputs 0; a new r1 request is granted first only when r0 is idle.
